sequential_alu: RTL and testbench
=================================

// Module: sequential_alu
// PURPOSE
//   Parametrised, multi-cycle successor to the datapath ALU. Keeps the single-cycle
//   ADD/SUB/CMP/AND/OR/XOR set and adds a bit-serial shifter (LSH) and a shift-add
//   multiplier (MUL). Results and status flags are registered. A start/busy/done
//   handshake lets the control FSM stall the datapath while a multi-cycle op runs.
// PARAMETERS
//   WIDTH       16  operand/result width in bits; must be >= 4.
//   SHAMT_BITS  5   width of the signed shift amount taken from b[SHAMT_BITS-1:0];
//                   must equal clog2(WIDTH)+1.
// PORTS
//   clock      in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   start      in   1      launch operation; sampled only in IDLE
//   operation  in   3      000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 LSH, 111 MUL
//   a          in   WIDTH  operand A; captured on accepted start
//   b          in   WIDTH  operand B or shift amount; captured on accepted start
//   busy       out  1      high from the cycle after an accepted start until done
//   done       out  1      one-cycle pulse; result and flags are valid from this cycle
//   result     out  WIDTH  registered result; held until the next done
//   carry      out  1      PSR C
//   low        out  1      PSR L
//   flag       out  1      PSR F
//   zero       out  1      PSR Z
//   negative   out  1      PSR N
// BEHAVIOUR
//   - Reset (reset=0, async): state IDLE; busy, done, result and all flags are 0.
//     Asserting reset mid-operation aborts the op; no done is produced.
//   - FSM states: IDLE, SHIFT, MULTIPLY, FINISH.
//     IDLE + start + single-cycle op -> FINISH. IDLE + start + LSH with amount != 0 -> SHIFT.
//     LSH with amount 0 -> FINISH. IDLE + start + MUL -> MULTIPLY.
//     SHIFT -> FINISH when the remaining count reaches 0.
//     MULTIPLY -> FINISH after WIDTH iterations.
//     FINISH -> IDLE; done=1 for that cycle only.
//   - Latency, from the start edge to the done cycle:
//     single-cycle ops = 1; LSH = |amount|+1; MUL = WIDTH+1.
//   - start is ignored unless the state is IDLE; busy=0 in IDLE and FINISH.
//     A start asserted in the FINISH cycle is ignored. Back-to-back throughput is one op
//     per 2 cycles minimum.
//   - Operands are latched at start. Changes to a, b or operation while busy have no effect.
//   - result, carry, low, flag, zero and negative update only on the edge entering FINISH.
//     Flags not listed for an operation are written 0.
//   - ADD: result = a+b mod 2^WIDTH; C = unsigned carry-out;
//     F = signed overflow (sign(a)==sign(b) && sign(result)!=sign(a)); Z = (result==0).
//   - SUB: result = a-b mod 2^WIDTH; C = borrow (a<b unsigned);
//     F = signed overflow (sign(a)!=sign(b) && sign(result)!=sign(a)); Z = (result==0).
//   - CMP: result = a-b; Z = (a==b); L = (a<b unsigned); N = (a<b signed).
//   - AND/OR/XOR: bitwise; Z = (result==0).
//   - LSH: amount = signed b[SHAMT_BITS-1:0]. Positive shifts left logically and
//     negative shifts right logically, one bit per cycle with zero fill.
//     If |amount| >= WIDTH, result = 0 (all bits shifted out). C = last bit shifted out
//     (0 if amount = 0). Z = (result==0).
//   - MUL: unsigned shift-add over WIDTH iterations; result = low WIDTH bits of a*b.
//     C = 1 if any of the high WIDTH product bits is nonzero. Z = (result==0).
//   - All arithmetic is internally WIDTH+1 bits; no X may propagate for any opcode.
// TESTING
//   1. WIDTH=16. ADD a=7FFF b=0001 -> done 1 cycle after start; result=8000, F=1, C=0, Z=0.
//   2. SUB a=0003 b=0005 -> result=FFFE, C=1, F=0.
//      CMP a=8000 b=0001 -> L=0, N=1, Z=0.
//   3. LSH a=0081 b=0003 -> busy 3 cycles, done at cycle 4, result=0408.
//      LSH a=0081 b=001F (-1) -> result=0040, C=1. LSH b=0 -> latency 1, result=a.
//   4. MUL a=0100 b=0100 -> done at cycle 17; result=0000, C=1, Z=1.
//      MUL a=00FF b=0003 -> result=02FD, C=0.
//   5. Pulse start every cycle during a MUL with differing a/b -> exactly one done.
//      Result matches the operands latched at the accepted start.
//   6. Drop reset at cycle 5 of a MUL -> all outputs 0 immediately, no done.
//      Release reset and issue ADD 0001+0001 -> result=0002 after 1 cycle.

Source files
------------

// File: rtl/sequential_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus a bit-serial shifter and a
// shift-add multiplier, behind a start/busy/done handshake with registered result and flags.
module sequential_alu #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned SHAMT_BITS = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             low,
   output logic             flag,
   output logic             zero,
   output logic             negative
);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpCmp = 3'b010;
   localparam logic [2:0] OpAnd = 3'b011;
   localparam logic [2:0] OpOr  = 3'b100;
   localparam logic [2:0] OpXor = 3'b101;
   localparam logic [2:0] OpLsh = 3'b110;
   localparam logic [2:0] OpMul = 3'b111;

   typedef enum logic [1:0] {StIdle, StShift, StMultiply, StFinish} state_e;

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0]      work_q, work_d;
   logic [WIDTH-1:0]      hi_q, hi_d;
   logic [SHAMT_BITS-1:0] cnt_q, cnt_d;
   logic                  left_q, left_d;
   logic [WIDTH-1:0]      result_q, result_d;
   logic                  carry_q, carry_d;
   logic                  low_q, low_d;
   logic                  flag_q, flag_d;
   logic                  zero_q, zero_d;
   logic                  negative_q, negative_d;

   logic [SHAMT_BITS-1:0] amt_raw, amt_mag;
   logic                  amt_neg;
   logic [WIDTH:0]        sum_w, diff_w, mul_sum;
   logic [WIDTH-1:0]      shifted, mul_hi, mul_lo;
   logic                  shift_out;

   logic [WIDTH-1:0]      quick_res;
   logic                  quick_c, quick_l, quick_f, quick_n;

   assign amt_raw = b[SHAMT_BITS-1:0];
   assign amt_neg = amt_raw[SHAMT_BITS-1];
   assign amt_mag = amt_neg ? (~amt_raw + SHAMT_BITS'(1)) : amt_raw;

   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};

   assign shifted   = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
   assign shift_out = left_q ? work_q[WIDTH-1] : work_q[0];

   // One shift-add step: work_q holds the unconsumed multiplier bits, hi_q the partial sum.
   assign mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], work_q[WIDTH-1:1]};

   always_comb begin
      quick_res = '0;
      quick_c   = 1'b0;
      quick_l   = 1'b0;
      quick_f   = 1'b0;
      quick_n   = 1'b0;
      unique case (operation)
         OpAdd: begin
            quick_res = sum_w[WIDTH-1:0];
            quick_c   = sum_w[WIDTH];
            quick_f   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub: begin
            quick_res = diff_w[WIDTH-1:0];
            quick_c   = diff_w[WIDTH];
            quick_f   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
         end
         OpCmp: begin
            quick_res = diff_w[WIDTH-1:0];
            quick_l   = diff_w[WIDTH];
            quick_n   = $signed(a) < $signed(b);
         end
         OpAnd: quick_res = a & b;
         OpOr:  quick_res = a | b;
         OpXor: quick_res = a ^ b;
         OpLsh: quick_res = a;
         OpMul: quick_res = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      work_d     = work_q;
      hi_d       = hi_q;
      cnt_d      = cnt_q;
      left_d     = left_q;
      result_d   = result_q;
      carry_d    = carry_q;
      low_d      = low_q;
      flag_d     = flag_q;
      zero_d     = zero_q;
      negative_d = negative_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               if (operation == OpMul) begin
                  mcand_d = a;
                  work_d  = b;
                  hi_d    = '0;
                  cnt_d   = SHAMT_BITS'(WIDTH);
                  state_d = StMultiply;
               end else if (operation == OpLsh && amt_mag != '0) begin
                  work_d  = a;
                  cnt_d   = amt_mag;
                  left_d  = ~amt_neg;
                  state_d = StShift;
               end else begin
                  result_d   = quick_res;
                  carry_d    = quick_c;
                  low_d      = quick_l;
                  flag_d     = quick_f;
                  zero_d     = (quick_res == '0);
                  negative_d = quick_n;
                  state_d    = StFinish;
               end
            end
         end
         StShift: begin
            work_d = shifted;
            cnt_d  = cnt_q - SHAMT_BITS'(1);
            if (cnt_q == SHAMT_BITS'(1)) begin
               result_d   = shifted;
               carry_d    = shift_out;
               low_d      = 1'b0;
               flag_d     = 1'b0;
               zero_d     = (shifted == '0);
               negative_d = 1'b0;
               state_d    = StFinish;
            end
         end
         StMultiply: begin
            hi_d   = mul_hi;
            work_d = mul_lo;
            cnt_d  = cnt_q - SHAMT_BITS'(1);
            if (cnt_q == SHAMT_BITS'(1)) begin
               result_d   = mul_lo;
               carry_d    = |mul_hi;
               low_d      = 1'b0;
               flag_d     = 1'b0;
               zero_d     = (mul_lo == '0);
               negative_d = 1'b0;
               state_d    = StFinish;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         mcand_q    <= '0;
         work_q     <= '0;
         hi_q       <= '0;
         cnt_q      <= '0;
         left_q     <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         low_q      <= 1'b0;
         flag_q     <= 1'b0;
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         work_q     <= work_d;
         hi_q       <= hi_d;
         cnt_q      <= cnt_d;
         left_q     <= left_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         low_q      <= low_d;
         flag_q     <= flag_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
      end
   end

   assign busy     = (state_q == StShift) || (state_q == StMultiply);
   assign done     = (state_q == StFinish);
   assign result   = result_q;
   assign carry    = carry_q;
   assign low      = low_q;
   assign flag     = flag_q;
   assign zero     = zero_q;
   assign negative = negative_q;

endmodule

// File: tb/tb_sequential_alu.sv
// Bench for sequential_alu: directed vectors, randomized ops against an arithmetic
// reference model, start-while-busy and reset-abort scenarios.
module tb_sequential_alu;

   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    operation = 3'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done, carry, low, flag, zero, negative;
   logic [W-1:0]  result;

   int total = 0;
   int bad   = 0;

   sequential_alu #(.WIDTH(16), .SHAMT_BITS(5)) dut (
      .clock(clock), .reset(reset), .start(start), .operation(operation),
      .a(a), .b(b), .busy(busy), .done(done), .result(result),
      .carry(carry), .low(low), .flag(flag), .zero(zero), .negative(negative)
   );

   always #5 clock = ~clock;

   // Reference model: fl = {C, L, F, Z, N}; lat = start edge to done cycle.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y, output logic [W-1:0] r,
                                 output logic [4:0] fl, output int lat);
      int ux, uy, sx, sy, t, amt, m;
      longint p;
      logic c, l, f, n;
      ux = int'(x); uy = int'(y);
      sx = int'($signed(x)); sy = int'($signed(y));
      c = 1'b0; l = 1'b0; f = 1'b0; n = 1'b0; lat = 1; t = 0;
      case (op)
         3'd0: begin
            t = ux + uy; c = (t > 65535);
            f = (sx + sy > 32767) || (sx + sy < -32768);
         end
         3'd1: begin
            t = ux - uy; c = (ux < uy);
            f = (sx - sy > 32767) || (sx - sy < -32768);
         end
         3'd2: begin t = ux - uy; l = (ux < uy); n = (sx < sy); end
         3'd3: t = ux & uy;
         3'd4: t = ux | uy;
         3'd5: t = ux ^ uy;
         3'd6: begin
            amt = int'(y[4:0]);
            if (amt >= 16) amt = amt - 32;
            if (amt == 0) begin
               t = ux;
            end else if (amt > 0) begin
               t = ux << amt; c = x[16 - amt]; lat = amt + 1;
            end else begin
               m = -amt;
               t = (m >= 16) ? 0 : (ux >> m); c = x[m - 1]; lat = m + 1;
            end
         end
         default: begin
            p = longint'(ux) * longint'(uy);
            t = int'(p & 64'hFFFF); c = (p > 65535); lat = 17;
         end
      endcase
      r = t[15:0];
      fl = {c, l, f, (r == 16'h0000), n};
   endfunction

   // Launch one op from an idle cycle and collect its outputs; inputs are scrambled after
   // acceptance so latching is exercised on every op.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] r, output logic [4:0] fl, output int lat,
                         output int busy_cnt, output logic done_after);
      operation = op; a = ia; b = ib; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; operation = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
      lat = 1; busy_cnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clock); #1;
         lat++;
      end
      r = result;
      fl = {carry, low, flag, zero, negative};
      @(posedge clock); #1;
      done_after = done;
   endtask

   task automatic test_reset;
      #2;
      total++;
      if ({busy, done, result, carry, low, flag, zero, negative} !== 22'h0) begin
         bad++;
         $display("FAIL reset_state: got %h want 0",
                  {busy, done, result, carry, low, flag, zero, negative});
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      total++;
      if ({busy, done, result, carry, low, flag, zero, negative} !== 22'h0) begin
         bad++;
         $display("FAIL idle_after_reset: got %h want 0",
                  {busy, done, result, carry, low, flag, zero, negative});
      end
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [4:0]   fl;
      int           lat;
   } vec_t;

   task automatic test_directed;
      vec_t v [8];
      logic [W-1:0] r;
      logic [4:0] fl;
      int lat, bc;
      logic da;
      v[0] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1};
      v[1] = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 5'b10000, 1};
      v[2] = '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 5'b00001, 1};
      v[3] = '{3'd6, 16'h0081, 16'h0003, 16'h0408, 5'b00000, 4};
      v[4] = '{3'd6, 16'h0081, 16'h001F, 16'h0040, 5'b10000, 2};
      v[5] = '{3'd6, 16'h0081, 16'h0000, 16'h0081, 5'b00000, 1};
      v[6] = '{3'd7, 16'h0100, 16'h0100, 16'h0000, 5'b10010, 17};
      v[7] = '{3'd7, 16'h00FF, 16'h0003, 16'h02FD, 5'b00000, 17};
      for (int i = 0; i < 8; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, r, fl, lat, bc, da);
         total++;
         if ({r, fl} !== {v[i].r, v[i].fl}) begin
            bad++;
            $display("FAIL directed_%0d_value: got r=%h f=%b want r=%h f=%b",
                     i, r, fl, v[i].r, v[i].fl);
         end
         total++;
         if (lat != v[i].lat || bc != v[i].lat - 1) begin
            bad++;
            $display("FAIL directed_%0d_timing: got lat=%0d busy=%0d want lat=%0d busy=%0d",
                     i, lat, bc, v[i].lat, v[i].lat - 1);
         end
         total++;
         if (da !== 1'b0) begin
            bad++;
            $display("FAIL directed_%0d_done_pulse: got done=%b after done cycle want 0", i, da);
         end
      end
   endtask

   task automatic test_random;
      logic [2:0] op;
      logic [W-1:0] x, y, r, er;
      logic [4:0] fl, ef;
      int lat, el, bc;
      logic da;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom); x = 16'($urandom); y = 16'($urandom);
         if (i % 4 == 0) op = 3'd6;
         model(op, x, y, er, ef, el);
         run_op(op, x, y, r, fl, lat, bc, da);
         total++;
         if ({r, fl} !== {er, ef} || lat != el) begin
            bad++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: got r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                     i, op, x, y, r, fl, lat, er, ef, el);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] op;
      logic [W-1:0] x, y, r, er;
      logic [4:0] fl, ef;
      int lat, el, bc;
      logic da;
      for (int i = 0; i < 12; i++) begin
         op = 3'($urandom_range(5, 0)); x = 16'($urandom); y = 16'($urandom);
         model(op, x, y, er, ef, el);
         run_op(op, x, y, r, fl, lat, bc, da);
         total++;
         if ({r, fl} !== {er, ef} || lat != 1 || da !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back_%0d: got r=%h f=%b lat=%0d want r=%h f=%b lat=1",
                     i, r, fl, lat, er, ef);
         end
      end
   endtask

   task automatic test_start_during_busy;
      logic [W-1:0] x, y, er, r;
      logic [4:0] ef, fl;
      int el, lat, extra;
      logic busy_after;
      x = 16'($urandom); y = 16'($urandom);
      model(3'd7, x, y, er, ef, el);
      operation = 3'd7; a = x; b = y; start = 1'b1;
      @(posedge clock); #1;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         operation = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
         @(posedge clock); #1;
         lat++;
      end
      r = result; fl = {carry, low, flag, zero, negative};
      // start is still high through the done cycle and must be ignored there
      operation = 3'($urandom_range(5, 0));
      @(posedge clock); #1;
      start = 1'b0;
      busy_after = busy;
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) extra++;
         @(posedge clock); #1;
      end
      total++;
      if ({r, fl} !== {er, ef} || lat != el) begin
         bad++;
         $display("FAIL start_busy_value: got r=%h f=%b lat=%0d want r=%h f=%b lat=%0d",
                  r, fl, lat, er, ef, el);
      end
      total++;
      if (extra != 0 || busy_after !== 1'b0) begin
         bad++;
         $display("FAIL start_busy_ignored: got extra_done=%0d busy=%b want 0 0",
                  extra, busy_after);
      end
   endtask

   task automatic test_reset_abort;
      int ndone;
      logic [W-1:0] r;
      logic [4:0] fl;
      int lat, bc;
      logic da;
      operation = 3'd7; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      reset = 1'b0;
      #1;
      total++;
      if ({busy, done, result, carry, low, flag, zero, negative} !== 22'h0) begin
         bad++;
         $display("FAIL abort_outputs: got %h want 0",
                  {busy, done, result, carry, low, flag, zero, negative});
      end
      ndone = 0;
      repeat (3) begin @(posedge clock); #1; if (done === 1'b1) ndone++; end
      reset = 1'b1;
      repeat (20) begin @(posedge clock); #1; if (done === 1'b1) ndone++; end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL abort_no_done: got %0d dones want 0", ndone);
      end
      run_op(3'd0, 16'h0001, 16'h0001, r, fl, lat, bc, da);
      total++;
      if (r !== 16'h0002 || fl !== 5'b00000 || lat != 1) begin
         bad++;
         $display("FAIL abort_then_add: got r=%h f=%b lat=%0d want r=0002 f=00000 lat=1",
                  r, fl, lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_start_during_busy();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
